// File: rtl/handle_table_if.sv
// ============================================================================
//  handle_table_if : command, response and translation channels of handle_table
//  Revision 1.0
// ============================================================================
`default_nettype none

interface handle_table_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int HNDL_WIDTH = 8
);
    localparam int OFFS_WIDTH = ADDR_WIDTH - HNDL_WIDTH - 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [HNDL_WIDTH-1:0] cmd_handle;
    logic [OFFS_WIDTH-1:0] cmd_base;
    logic [OFFS_WIDTH-1:0] cmd_limit;

    logic                  rsp_valid;
    logic                  rsp_err;
    logic [HNDL_WIDTH-1:0] rsp_handle;
    logic [OFFS_WIDTH-1:0] rsp_data;
    logic [HNDL_WIDTH-1:0] free_count;

    logic                  xl_valid;
    logic                  xl_ready;
    logic [ADDR_WIDTH-1:0] xl_addr;

    logic                  pa_valid;
    logic                  pa_ready;
    logic [ADDR_WIDTH-1:0] pa_addr;
    logic                  pa_fault;

    modport master (
        output cmd_valid, cmd_op, cmd_handle, cmd_base, cmd_limit,
        output xl_valid, xl_addr, pa_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_handle, rsp_data, free_count,
        input  xl_ready, pa_valid, pa_addr, pa_fault
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_handle, cmd_base, cmd_limit,
        input  xl_valid, xl_addr, pa_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_handle, rsp_data, free_count,
        output xl_ready, pa_valid, pa_addr, pa_fault
    );
endinterface

`default_nettype wire

// File: rtl/handle_table.sv
// ============================================================================
//  handle_table : handle->address map with alloc/free/remap/query commands
//                 and a registered, bounds-checked address translation channel
//  Revision 1.0
// ============================================================================
`default_nettype none

module handle_table #(
    parameter int ADDR_WIDTH = 64,
    parameter int HNDL_WIDTH = 8
) (
    input logic           clock,
    input logic           reset_n,
    handle_table_if.slave bus
);
    localparam int N          = 2 ** HNDL_WIDTH;
    localparam int OFFS_WIDTH = ADDR_WIDTH - HNDL_WIDTH - 1;

    localparam logic [1:0] OP_ALLOC  = 2'd0;
    localparam logic [1:0] OP_FREE   = 2'd1;
    localparam logic [1:0] OP_SETMAP = 2'd2;
    localparam logic [1:0] OP_QUERY  = 2'd3;

    localparam logic [HNDL_WIDTH-1:0] ONE_H     = {{(HNDL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HNDL_WIDTH-1:0] LAST_IDX  = {HNDL_WIDTH{1'b1}};
    localparam logic [HNDL_WIDTH-1:0] FREE_INIT = {HNDL_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]            valid;
    logic [OFFS_WIDTH-1:0]   base_mem  [N];
    logic [OFFS_WIDTH-1:0]   limit_mem [N];
    logic [HNDL_WIDTH-1:0]   clr_idx;

    logic                    cmd_fire;
    logic                    xl_fire;
    logic                    hdl_valid;
    logic                    alloc_found;
    logic [HNDL_WIDTH-1:0]   alloc_h;
    logic                    alloc_ok;
    logic                    free_ok;
    logic                    setmap_ok;
    logic                    write_en;
    logic [HNDL_WIDTH-1:0]   write_idx;

    logic                    xl_flag;
    logic [HNDL_WIDTH-1:0]   xl_hdl;
    logic [OFFS_WIDTH-1:0]   xl_off;
    logic [OFFS_WIDTH:0]     xl_sum;
    logic                    xl_hit;
    logic [ADDR_WIDTH-1:0]   xl_pa;
    logic                    xl_fault;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == S_CLEAR) begin
                clr_idx <= clr_idx + ONE_H;
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.xl_ready  = 1'b0;
        case (state)
            S_CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                bus.cmd_ready = 1'b1;
                bus.xl_ready  = !bus.pa_valid || bus.pa_ready;
            end
            default: state_next = S_CLEAR;
        endcase
    end

    // ---------------- command decode ----------------
    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign xl_fire   = bus.xl_valid && bus.xl_ready;
    assign hdl_valid = valid[bus.cmd_handle];

    // Lowest free handle; the descending scan lets the smallest index win. Handle 0 is skipped.
    always_comb begin
        alloc_found = 1'b0;
        alloc_h     = '0;
        for (int i = N - 1; i >= 1; i--) begin
            if (!valid[i]) begin
                alloc_found = 1'b1;
                alloc_h     = HNDL_WIDTH'(i);
            end
        end
    end

    assign alloc_ok  = cmd_fire && (bus.cmd_op == OP_ALLOC) && alloc_found;
    assign free_ok   = cmd_fire && (bus.cmd_op == OP_FREE) && hdl_valid && (bus.cmd_handle != '0);
    assign setmap_ok = cmd_fire && (bus.cmd_op == OP_SETMAP) && hdl_valid;
    assign write_en  = alloc_ok || setmap_ok;
    assign write_idx = alloc_ok ? alloc_h : bus.cmd_handle;

    // Table storage is RAM-like: only the valid bits are swept, never by the async reset.
    always_ff @(posedge clock) begin
        if (state == S_CLEAR) begin
            valid[clr_idx] <= 1'b0;
        end else if (alloc_ok) begin
            valid[alloc_h] <= 1'b1;
        end else if (free_ok) begin
            valid[bus.cmd_handle] <= 1'b0;
        end
        if (write_en) begin
            base_mem[write_idx]  <= bus.cmd_base;
            limit_mem[write_idx] <= bus.cmd_limit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_handle <= '0;
            bus.rsp_data   <= '0;
            bus.free_count <= FREE_INIT;
        end else begin
            bus.rsp_valid  <= cmd_fire;
            bus.rsp_err    <= 1'b0;
            bus.rsp_handle <= '0;
            bus.rsp_data   <= '0;
            if (cmd_fire) begin
                case (bus.cmd_op)
                    OP_ALLOC: begin
                        bus.rsp_err    <= !alloc_found;
                        bus.rsp_handle <= alloc_h;
                    end
                    OP_FREE: begin
                        bus.rsp_err    <= !free_ok;
                        bus.rsp_handle <= bus.cmd_handle;
                    end
                    OP_SETMAP: begin
                        bus.rsp_err    <= !setmap_ok;
                        bus.rsp_handle <= bus.cmd_handle;
                    end
                    OP_QUERY: begin
                        bus.rsp_err    <= !hdl_valid;
                        bus.rsp_handle <= bus.cmd_handle;
                        bus.rsp_data   <= hdl_valid ? base_mem[bus.cmd_handle] : '0;
                    end
                endcase
            end
            if (alloc_ok) begin
                bus.free_count <= bus.free_count - ONE_H;
            end else if (free_ok) begin
                bus.free_count <= bus.free_count + ONE_H;
            end
        end
    end

    // ---------------- translation ----------------
    assign xl_flag = bus.xl_addr[ADDR_WIDTH-1];
    assign xl_hdl  = bus.xl_addr[ADDR_WIDTH-2:OFFS_WIDTH];
    assign xl_off  = bus.xl_addr[OFFS_WIDTH-1:0];
    assign xl_sum  = {1'b0, base_mem[xl_hdl]} + {1'b0, xl_off};
    assign xl_hit  = valid[xl_hdl] && (xl_off < limit_mem[xl_hdl]);

    always_comb begin
        xl_pa    = bus.xl_addr;
        xl_fault = 1'b0;
        if (xl_flag) begin
            if (xl_hit) begin
                xl_pa = {{HNDL_WIDTH{1'b0}}, xl_sum};
            end else begin
                xl_pa    = '0;
                xl_fault = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.pa_valid <= 1'b0;
            bus.pa_addr  <= '0;
            bus.pa_fault <= 1'b0;
        end else if (xl_fire) begin
            bus.pa_valid <= 1'b1;
            bus.pa_addr  <= xl_pa;
            bus.pa_fault <= xl_fault;
        end else if (bus.pa_ready) begin
            bus.pa_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: doc/handle_table.md
# handle_table

Parametrised, multi-entry successor to the single object cell: one block holds the whole handle→address map and replaces the per-handle cell array plus triand bus. It sits in front of virtual address translation. It accepts allocate/free/remap/query commands on one channel and translates handle-tagged addresses to flat addresses on a second, pipelined channel. It adds bounds checking, fault reporting, lowest-free allocation and a free-handle counter.

## Interface
- ADDR_WIDTH, 64: full address width (W).
- HNDL_WIDTH, 8: handle id width (H); table depth N = 2^H; offset width O = W-H-1.
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  0=ALLOC, 1=FREE, 2=SETMAP, 3=QUERY.
- cmd_handle  in  H  target handle (FREE/SETMAP/QUERY).
- cmd_base  in  O  base address (ALLOC/SETMAP).
- cmd_limit  in  O  object size in bytes (ALLOC/SETMAP).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  command failed; no state changed.
- rsp_handle  out  H  allocated/affected handle.
- rsp_data  out  O  QUERY: base; otherwise 0.
- free_count  out  H  number of free handles.
- xl_valid  in  1  translation request.
- xl_ready  out  1  request accepted when xl_valid & xl_ready.
- xl_addr  in  W  bit W-1 = handle flag; [W-2:O] = handle; [O-1:0] = offset.
- pa_valid  out  1  result valid; held until pa_ready.
- pa_ready  in  1  downstream accept.
- pa_addr  out  W  translated address.
- pa_fault  out  1  translation fault.

## Operation
- Per-entry storage: valid, base[O], limit[O]. Base/limit are not reset (RAM-like). Valid is cleared by a sweep.
- Handle 0 is the null handle. It is never allocated, never valid, and always faults.
- FSM CLEAR: entered on reset. Clears one valid bit per cycle, entries 0..N-1. cmd_ready=0 and xl_ready=0 throughout. After entry N-1, moves to RUN.
- FSM RUN: cmd_ready=1. xl_ready = !pa_valid | pa_ready.
- ALLOC: picks the lowest-numbered invalid handle ≥1 and writes base/limit/valid=1.
  - free_count decrements.
  - Response: rsp_handle = that handle.
  - If no handle is free: rsp_err=1, rsp_handle=0.
- FREE: if the handle is valid and nonzero, clears valid and free_count increments. Otherwise rsp_err=1.
- SETMAP: if the handle is valid, overwrites base and limit. Otherwise rsp_err=1 and nothing is written.
- QUERY: if valid, rsp_data = base. Otherwise rsp_err=1 and rsp_data=0.
- Translation, flag=0: pa_addr = xl_addr, pa_fault=0 (passthrough).
- Translation, flag=1, handle valid and offset < limit: pa_addr = zero-extend(base + offset), computed in O+1 bits (no wrap), pa_fault=0.
- Translation, any other flag=1 case: pa_fault=1, pa_addr=0.
- A limit of 0 makes every offset fault.

## Timing
- Reset values: cmd_ready=0, xl_ready=0, rsp_valid=0, rsp_err=0, rsp_handle=0, rsp_data=0, pa_valid=0, pa_addr=0, pa_fault=0, free_count=N-1. FSM=CLEAR.
- Reset length: CLEAR lasts exactly N cycles after reset_n deasserts. cmd_ready and xl_ready rise on cycle N.
- Command latency: 1 cycle. A command accepted at edge k produces rsp_valid high for the cycle after edge k. Back-to-back commands are allowed, one per cycle.
- Translation latency: 1 cycle, registered. pa_* holds stable while pa_valid & !pa_ready. Full throughput when pa_ready=1.
- Same-cycle command and translation: the translation uses table state before the command's edge. Example: a FREE of handle h and a translate of h in the same cycle gives a successful translation; the next cycle faults.
- ALLOC and FREE rely on the same ordering. A handle freed at edge k is allocatable by a command at edge k+1.
- free_count updates on the same edge the command commits.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Any in-flight response or translation is dropped and CLEAR restarts from entry 0.

## Test plan
- Parameters W=16, H=3 (O=12) unless noted. Reset, then wait 8 cycles: cmd_ready rises on cycle 8, free_count=7, translate 0x1234 -> pa 0x1234, fault 0.
- ALLOC base 0x100, limit 0x40 -> rsp_handle 1, err 0. Translate 0x9010 -> pa 0x0110. Translate 0x9040 -> fault, pa 0. Translate 0xA000 (handle 2, unallocated) -> fault.
- Seven ALLOCs -> handles 1..7 and free_count 0. Eighth ALLOC -> err 1, handle 0. FREE 3 then ALLOC -> handle 3. FREE 0 -> err 1. QUERY 5 -> rsp_data = its base.
- Handle 1 mapped to base 0xFFF, limit 0xFFF. Translate 0x9FFE -> pa 0x1FFD (carry kept, no wrap). SETMAP 1 to base 0x200 -> the next translate of 0x9001 gives 0x0201.
- Same-cycle FREE 1 and translate 0x9000 -> translation succeeds; the following translate faults. Hold pa_ready=0 for 3 cycles -> pa_* stable and xl_ready=0.
- Pull reset_n low in the middle of a translate stream -> outputs reset immediately, free_count=7, 8-cycle CLEAR repeats, and the earlier handle 1 now faults.
